// File: rtl/rr_sel_pkg.sv
// Shared types and helpers for the round-robin select mux and its arbiter.
package rr_sel_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Index of the set bit in a one-hot vector (0 when the vector is zero).
  function automatic int onehot_to_idx(input logic [MAX_CH-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant logic: fixed-priority or round-robin search over the requesters that
// the lock mask still allows. Purely combinational.
module rr_arbiter
  import rr_sel_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int PTR_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  mode_e            mode,
  input  logic [N_CH-1:0]  lock_mask,
  output logic [N_CH-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [N_CH-1:0]   req_masked;
  logic [MAX_CH-1:0] grant_ext;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
      assign req_masked[gi] = req[gi] & lock_mask[gi];
    end
  endgenerate

  // Walk the channels starting at ptr (round-robin) or at 0 (fixed); first hit wins.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int c;
      c = (mode == MODE_RR) ? int'(ptr) + k : k;
      if (c >= N_CH) c = c - N_CH;
      if (!found && req_masked[c]) begin
        grant[c] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Binary index of the granted channel, used for the data mux and the pointer.
  always_comb begin
    grant_ext            = '0;
    grant_ext[N_CH-1:0]  = grant;
    grant_idx            = PTR_W'(onehot_to_idx(grant_ext));
  end

  assign grant_valid = |grant;

endmodule

// File: rtl/rr_sel_mux.sv
// N-channel valid/ready select mux with an internal arbiter and one output
// register stage. Holds the output register, the round-robin pointer and the
// optional packet-lock state machine.
module rr_sel_mux
  import rr_sel_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int MODE = 1,
  parameter int LOCK = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_CH-1:0]   i_valid,
  input  logic [N_CH*W-1:0] i_data,
  input  logic [N_CH-1:0]   i_last,
  output logic [N_CH-1:0]   o_ready,
  output logic              o_valid,
  output logic [W-1:0]      o_data,
  output logic              o_last,
  output logic [N_CH-1:0]   o_sel,
  input  logic              i_ready
);

  localparam int    PTR_W    = $clog2(N_CH);
  localparam mode_e ARB_MODE = (MODE != 0) ? MODE_RR : MODE_FIXED;

  logic              o_valid_reg;
  logic [W-1:0]      o_data_reg;
  logic              o_last_reg;
  logic [N_CH-1:0]   o_sel_reg;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  lock_state_e       lock_state_reg, lock_state_next;
  logic [PTR_W-1:0]  lock_ch_reg, lock_ch_next;

  logic              load_en;
  logic [N_CH-1:0]   arb_req;
  logic [N_CH-1:0]   lock_mask;
  logic [N_CH-1:0]   grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_valid;
  logic [W-1:0]      sel_data;
  logic              sel_last;

  // The register can take a new beat when empty or when the consumer drains it.
  assign load_en = !o_valid_reg || i_ready;
  assign arb_req = i_valid & {N_CH{load_en}};

  // While locked, only the owning channel may win arbitration.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lock_mask
      assign lock_mask[gi] = (lock_state_reg == ST_IDLE) || (lock_ch_reg == PTR_W'(gi));
    end
  endgenerate

  rr_arbiter #(.N_CH(N_CH)) u_arbiter (
    .req         (arb_req),
    .ptr         (ptr_reg),
    .mode        (ARB_MODE),
    .lock_mask   (lock_mask),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel_data = i_data[int'(grant_idx)*W +: W];
  assign sel_last = i_last[grant_idx];

  // Next pointer and lock state; both only move when a beat is actually granted.
  always_comb begin
    ptr_next        = ptr_reg;
    lock_state_next = lock_state_reg;
    lock_ch_next    = lock_ch_reg;
    if (grant_valid) begin
      if (ARB_MODE == MODE_RR && lock_state_reg == ST_IDLE) begin
        ptr_next = (grant_idx == PTR_W'(N_CH-1)) ? '0 : grant_idx + 1'b1;
      end
      if (LOCK != 0) begin
        if (lock_state_reg == ST_IDLE) begin
          if (!sel_last) begin
            lock_state_next = ST_LOCKED;
            lock_ch_next    = grant_idx;
          end
        end else if (sel_last) begin
          lock_state_next = ST_IDLE;
        end
      end
    end
  end

  // State register for the pointer and the lock FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_reg        <= '0;
      lock_state_reg <= ST_IDLE;
      lock_ch_reg    <= '0;
    end else begin
      ptr_reg        <= ptr_next;
      lock_state_reg <= lock_state_next;
      lock_ch_reg    <= lock_ch_next;
    end
  end

  // Output register: load the granted beat, go empty when nobody requests, hold on stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_reg <= 1'b0;
      o_data_reg  <= '0;
      o_last_reg  <= 1'b0;
      o_sel_reg   <= '0;
    end else if (load_en) begin
      o_valid_reg <= grant_valid;
      o_sel_reg   <= grant;
      if (grant_valid) begin
        o_data_reg <= sel_data;
        o_last_reg <= sel_last;
      end
    end
  end

  assign o_ready = grant;
  assign o_valid = o_valid_reg;
  assign o_data  = o_data_reg;
  assign o_last  = o_last_reg;
  assign o_sel   = o_sel_reg;

endmodule

// File: tb/tb_rr_sel_mux.sv
// Bench for rr_sel_mux: four instances (RR, fixed priority, RR with packet
// lock, 3-channel RR) checked every cycle against a rule-level model, plus
// directed scenarios with literal expectations.
module tb_rr_sel_mux;

  localparam int NDUT = 4;
  localparam int NCH     [NDUT] = '{4, 4, 4, 3};
  localparam int MODE_OF [NDUT] = '{1, 0, 1, 1};
  localparam int LOCK_OF [NDUT] = '{0, 0, 1, 0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0]  vld [NDUT];
  logic [127:0] dat [NDUT];
  logic [15:0]  lst [NDUT];
  logic         rdy [NDUT];

  logic [15:0]  o_rdy [NDUT];
  logic         o_v   [NDUT];
  logic [7:0]   o_d   [NDUT];
  logic         o_l   [NDUT];
  logic [15:0]  o_s   [NDUT];

  int n_tests;
  int n_fail;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int N = NCH[gi];
      logic [N-1:0] rdy_w, sel_w;
      logic         v_w, l_w;
      logic [7:0]   d_w;
      rr_sel_mux #(.N_CH(N), .W(8), .MODE(MODE_OF[gi]), .LOCK(LOCK_OF[gi])) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (vld[gi][N-1:0]),
        .i_data  (dat[gi][N*8-1:0]),
        .i_last  (lst[gi][N-1:0]),
        .o_ready (rdy_w),
        .o_valid (v_w),
        .o_data  (d_w),
        .o_last  (l_w),
        .o_sel   (sel_w),
        .i_ready (rdy[gi])
      );
      assign o_rdy[gi] = 16'(rdy_w);
      assign o_v[gi]   = v_w;
      assign o_d[gi]   = d_w;
      assign o_l[gi]   = l_w;
      assign o_s[gi]   = 16'(sel_w);
    end
  endgenerate

  task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_valid [NDUT];
  logic [7:0] m_data [NDUT];
  bit        m_last  [NDUT];
  int        m_sel   [NDUT];
  int        m_ptr   [NDUT];
  bit        m_locked[NDUT];
  int        m_lch   [NDUT];

  // Channel that should win this cycle for instance k, or -1.
  function automatic int find_grant(int k);
    int n;
    n = NCH[k];
    for (int j = 0; j < n; j++) begin
      int c;
      c = (MODE_OF[k] == 1) ? (m_ptr[k] + j) % n : j;
      if (LOCK_OF[k] == 1 && m_locked[k] && c != m_lch[k]) continue;
      if (vld[k][c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NDUT; k++) begin
        m_valid[k] <= 1'b0; m_data[k] <= 8'h0; m_last[k] <= 1'b0; m_sel[k] <= -1;
        m_ptr[k] <= 0; m_locked[k] <= 1'b0; m_lch[k] <= 0;
      end
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        int g;
        g = find_grant(k);
        if (!m_valid[k] || rdy[k]) begin
          if (g >= 0) begin
            m_valid[k] <= 1'b1;
            m_data[k]  <= dat[k][g*8 +: 8];
            m_last[k]  <= lst[k][g];
            m_sel[k]   <= g;
            if (MODE_OF[k] == 1 && !(LOCK_OF[k] == 1 && m_locked[k])) m_ptr[k] <= (g + 1) % NCH[k];
            if (LOCK_OF[k] == 1) begin
              if (!m_locked[k] && !lst[k][g]) begin
                m_locked[k] <= 1'b1;
                m_lch[k]    <= g;
              end else if (m_locked[k] && lst[k][g]) begin
                m_locked[k] <= 1'b0;
              end
            end
          end else begin
            m_valid[k] <= 1'b0;
            m_sel[k]   <= -1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit         st_prev [NDUT];
  logic [7:0] d_prev  [NDUT];
  logic [15:0] s_prev [NDUT];

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      int g;
      logic [15:0] er;
      g  = find_grant(k);
      er = ((!m_valid[k] || rdy[k]) && g >= 0) ? (16'(1) << g) : 16'h0;
      chk("o_ready", k, o_rdy[k], er);
      chk("o_valid", k, 16'(o_v[k]), 16'(m_valid[k]));
      chk("o_sel", k, o_s[k], (m_sel[k] < 0) ? 16'h0 : (16'(1) << m_sel[k]));
      chk("o_data", k, 16'(o_d[k]), 16'(m_data[k]));
      chk("o_last", k, 16'(o_l[k]), 16'(m_last[k]));
      n_tests++;
      assert ($onehot0(o_rdy[k]) && $onehot0(o_s[k]) && ((o_s[k] != 0) == o_v[k]))
      else begin
        n_fail++;
        $display("FAIL onehot_inv dut%0d: got ready=%0h sel=%0h valid=%0b required onehot0 and sel!=0 iff valid", k, o_rdy[k], o_s[k], o_v[k]);
      end
      if (st_prev[k] && rst_n) begin
        n_tests++;
        assert (o_d[k] == d_prev[k] && o_s[k] == s_prev[k])
        else begin
          n_fail++;
          $display("FAIL stall_stable dut%0d: got data=%0h sel=%0h required data=%0h sel=%0h", k, o_d[k], o_s[k], d_prev[k], s_prev[k]);
        end
      end
      st_prev[k] <= o_v[k] && !rdy[k] && rst_n;
      d_prev[k]  <= o_d[k];
      s_prev[k]  <= o_s[k];
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [15:0] seq4 [5];
    logic [15:0] seq3 [7];
    logic [15:0] lv [5], ll [5], exp_rdy [5], exp_sel [5];
    logic [7:0]  ld1 [5], exp_dat [5];
    logic        exp_v [5];
    seq4    = '{16'h1, 16'h2, 16'h4, 16'h8, 16'h1};
    seq3    = '{16'h1, 16'h2, 16'h4, 16'h1, 16'h2, 16'h4, 16'h1};
    lv      = '{16'h2, 16'h1, 16'h3, 16'h3, 16'h1};
    ll      = '{16'h0, 16'h0, 16'h0, 16'h2, 16'h1};
    ld1     = '{8'h11, 8'h11, 8'h12, 8'h13, 8'h13};
    exp_rdy = '{16'h2, 16'h0, 16'h2, 16'h2, 16'h1};
    exp_sel = '{16'h2, 16'h0, 16'h2, 16'h2, 16'h1};
    exp_dat = '{8'h11, 8'h11, 8'h12, 8'h13, 8'hC0};
    exp_v   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      vld[k] = '0; lst[k] = '0; rdy[k] = 1'b1; dat[k] = '0;
      for (int c = 0; c < 16; c++) dat[k][c*8 +: 8] = 8'(16 * (k + 1) + c);
    end
    vld[0] = 16'hF;   // RR, all requesting
    vld[1] = 16'hA;   // fixed priority, ch1 and ch3

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 0, 16'(o_v[0]), 16'h0);
    chk("rst_sel", 0, o_s[0], 16'h0);
    chk("rst_data", 0, 16'(o_d[0]), 16'h0);

    // Round-robin rotation and fixed priority, side by side.
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rr4_seq", 0, o_s[0], seq4[i]);
      chk("rr4_valid", 0, 16'(o_v[0]), 16'h1);
      chk("fix_sel", 1, o_s[1], 16'h2);
      chk("fix_rdy3", 1, 16'(o_rdy[1][3]), 16'h0);
    end

    // Stall with A5 from ch2 held in the output register.
    @(posedge clk); #1 vld[0] = 16'h4; dat[0][23:16] = 8'hA5;
    @(posedge clk); #1 rdy[0] = 1'b0; dat[0][23:16] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data", 0, 16'(o_d[0]), 16'hA5);
      chk("stall_sel", 0, o_s[0], 16'h4);
      chk("stall_rdy", 0, o_rdy[0], 16'h0);
    end
    @(posedge clk); #1 rdy[0] = 1'b1;
    @(negedge clk);
    chk("drain_rdy", 0, o_rdy[0], 16'h4);
    chk("drain_data_old", 0, 16'(o_d[0]), 16'hA5);
    @(negedge clk);
    chk("drain_data_new", 0, 16'(o_d[0]), 16'h5A);
    @(posedge clk); #1 vld[0] = 16'h0;

    // Packet lock: ch1 owns the output for three beats while ch0 waits.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i < 5) begin
        vld[2] = lv[i]; lst[2] = ll[i]; dat[2][15:8] = ld1[i]; dat[2][7:0] = 8'hC0;
      end else begin
        vld[2] = 16'h0; lst[2] = 16'h0;
      end
      @(negedge clk);
      if (i > 0) begin
        chk("lock_sel", 2, o_s[2], exp_sel[i-1]);
        chk("lock_valid", 2, 16'(o_v[2]), 16'(exp_v[i-1]));
        chk("lock_data", 2, 16'(o_d[2]), 16'(exp_dat[i-1]));
      end
      if (i < 5) chk("lock_rdy", 2, o_rdy[2], exp_rdy[i]);
    end

    // Asynchronous reset in the middle of a locked, stalled packet.
    @(posedge clk); #1 vld[2] = 16'h4; lst[2] = 16'h0; rdy[2] = 1'b1;
    @(posedge clk); #1 rdy[2] = 1'b0; vld[3] = 16'h7;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async_valid", 2, 16'(o_v[2]), 16'h0);
    chk("async_sel", 2, o_s[2], 16'h0);
    chk("async_data", 2, 16'(o_d[2]), 16'h0);
    vld[2] = 16'hF; lst[2] = 16'hF; rdy[2] = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;

    // 3-channel wrap, and restart from ch0 on the locked instance.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rr3_seq", 3, o_s[3], seq3[i]);
      if (i == 0) chk("restart_sel", 2, o_s[2], 16'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
